// File: rtl/sayeh_pkg.sv
// Shared SAYEH definitions: flag bit positions and the default flag count.
package sayeh_pkg;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;

   localparam int DEFAULT_FLAG_W = 4;

endpackage

// File: rtl/sr_lifo.sv
// Shadow LIFO for the status register: storage array plus occupancy counter.
// The top of stack is entry depth-1. Requests that cannot be honoured
// (write when full, read/exchange when empty) are ignored here; error
// reporting is left to the caller.
module sr_lifo
   import sayeh_pkg::*;
#(
   parameter int WIDTH = DEFAULT_FLAG_W,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic             rd,
   input  logic             xchg,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] depth,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CNT_W-1:0] depth_q, depth_d;
   logic [AW-1:0]    top_idx, wr_idx;
   logic             push_we, xchg_we;

   assign full    = (depth_q == CNT_W'(DEPTH));
   assign empty   = (depth_q == '0);
   assign top_idx = empty ? '0 : AW'(depth_q - CNT_W'(1));
   assign wr_idx  = AW'(depth_q);
   assign dout    = mem_q[top_idx];
   assign depth   = depth_q;

   assign push_we = !rst && wr && !full;
   assign xchg_we = !rst && xchg && !empty;

   // Occupancy update: saturating increment on write, decrement on read.
   always_comb begin
      depth_d = depth_q;
      if (wr && !full) begin
         depth_d = depth_q + CNT_W'(1);
      end else if (rd && !empty) begin
         depth_d = depth_q - CNT_W'(1);
      end
   end

   // Occupancy register; falling edge to match the datapath.
   always_ff @(negedge clk) begin
      if (rst) begin
         depth_q <= '0;
      end else begin
         depth_q <= depth_d;
      end
   end

   // Storage array, not reset: entries are only visible after being written.
   always_ff @(negedge clk) begin
      if (push_we) begin
         mem_q[wr_idx] <= din;
      end else if (xchg_we) begin
         mem_q[top_idx] <= din;
      end
   end

endmodule

// File: rtl/status_flag_stack.sv
// SAYEH status register with per-bit load/set/reset masks, a shadow LIFO
// for save/restore around interrupts and calls, and sticky overflow and
// underflow error flags. All state changes on the falling clock edge.
module status_flag_stack
   import sayeh_pkg::*;
#(
   parameter  int FLAG_W      = DEFAULT_FLAG_W,
   parameter  int STACK_DEPTH = 4,
   localparam int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sr_load,
   input  logic [FLAG_W-1:0] load_mask,
   input  logic [FLAG_W-1:0] flags_in,
   input  logic [FLAG_W-1:0] set_mask,
   input  logic [FLAG_W-1:0] reset_mask,
   input  logic              push,
   input  logic              pop,
   input  logic              err_clr,
   output logic [FLAG_W-1:0] flags_out,
   output logic [CNT_W-1:0]  depth,
   output logic              full,
   output logic              empty,
   output logic              ovf_err,
   output logic              unf_err
);

   logic [FLAG_W-1:0] flags_q, flags_d, norm_flags, stack_top;
   logic              ovf_q, ovf_d, unf_q, unf_d;
   logic              pop_ok, lifo_wr, lifo_rd, lifo_xchg;

   // A pop only succeeds with something on the stack; push+pop on an empty
   // stack degrades to a plain push (and flags an underflow).
   assign pop_ok    = pop && !empty;
   assign lifo_xchg = push && pop_ok;
   assign lifo_rd   = pop_ok && !push;
   assign lifo_wr   = push && !pop_ok;

   sr_lifo #(
      .WIDTH (FLAG_W),
      .DEPTH (STACK_DEPTH),
      .CNT_W (CNT_W)
   ) u_lifo (
      .clk   (clk),
      .rst   (rst),
      .wr    (lifo_wr),
      .rd    (lifo_rd),
      .xchg  (lifo_xchg),
      .din   (flags_q),
      .dout  (stack_top),
      .depth (depth),
      .full  (full),
      .empty (empty)
   );

   // Flag next state: per-bit load > set > reset > hold, overridden by a
   // successful pop which restores the saved word.
   always_comb begin
      norm_flags = flags_q;
      for (int i = 0; i < FLAG_W; i++) begin
         if (sr_load && load_mask[i]) begin
            norm_flags[i] = flags_in[i];
         end else if (set_mask[i]) begin
            norm_flags[i] = 1'b1;
         end else if (reset_mask[i]) begin
            norm_flags[i] = 1'b0;
         end
      end
      flags_d = pop_ok ? stack_top : norm_flags;
   end

   // Sticky errors: a new error in the same cycle as err_clr keeps the flag set.
   always_comb begin
      ovf_d = (ovf_q && !err_clr) || (push && !pop && full);
      unf_d = (unf_q && !err_clr) || (pop && empty);
   end

   // Flag and error registers.
   always_ff @(negedge clk) begin
      if (rst) begin
         flags_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         flags_q <= flags_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign flags_out = flags_q;
   assign ovf_err   = ovf_q;
   assign unf_err   = unf_q;

endmodule

// File: tb/tb_status_flag_stack.sv
// Bench for status_flag_stack: directed scenarios plus a random phase.
// A reference model computes the expected outputs when each cycle's
// stimulus is driven; the result is queued and compared after the edge.
module tb_status_flag_stack;

   localparam int FW = 4;
   localparam int SD = 4;
   localparam int CW = 3;
   localparam int W  = FW + CW + 4;

   logic          clk = 1'b0;
   logic          rst, sr_load, push, pop, err_clr;
   logic [FW-1:0] load_mask, flags_in, set_mask, reset_mask;
   logic [FW-1:0] flags_out;
   logic [CW-1:0] depth;
   logic          full, empty, ovf_err, unf_err;

   int            n_checks = 0;
   int            n_errors = 0;

   logic [W-1:0]  exp_q[$];

   // reference model state
   logic [FW-1:0] m_flags;
   logic [FW-1:0] m_stk[$];
   logic          m_ovf, m_unf;

   always #5 clk = ~clk;

   status_flag_stack #(.FLAG_W(FW), .STACK_DEPTH(SD)) dut (
      .clk        (clk),
      .rst        (rst),
      .sr_load    (sr_load),
      .load_mask  (load_mask),
      .flags_in   (flags_in),
      .set_mask   (set_mask),
      .reset_mask (reset_mask),
      .push       (push),
      .pop        (pop),
      .err_clr    (err_clr),
      .flags_out  (flags_out),
      .depth      (depth),
      .full       (full),
      .empty      (empty),
      .ovf_err    (ovf_err),
      .unf_err    (unf_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance the model by one edge with the given stimulus.
   task automatic model_step(input logic r, ld, input logic [FW-1:0] lm, fi, sm, rm,
                             input logic ps, pp, ec);
      logic [FW-1:0] pre, nf;
      int            d;
      logic          os, us;
      if (r) begin
         m_flags = '0;
         m_stk.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         pre = m_flags;
         d   = m_stk.size();
         os  = 1'b0;
         us  = 1'b0;
         for (int i = 0; i < FW; i++) begin
            if (ld && lm[i])  nf[i] = fi[i];
            else if (sm[i])   nf[i] = 1'b1;
            else if (rm[i])   nf[i] = 1'b0;
            else              nf[i] = pre[i];
         end
         if (pp && ps && d > 0) begin
            nf = m_stk[d-1];
            m_stk[d-1] = pre;
         end else if (pp && d > 0) begin
            nf = m_stk.pop_back();
         end else begin
            if (pp) us = 1'b1;
            if (ps) begin
               if (d == SD) os = 1'b1;
               else m_stk.push_back(pre);
            end
         end
         m_flags = nf;
         m_ovf = (m_ovf & ~ec) | os;
         m_unf = (m_unf & ~ec) | us;
      end
   endtask

   // Drive one cycle: queue the model's prediction, wait for the falling
   // edge, then compare every output against the popped prediction.
   task automatic drive(input logic r, ld, input logic [FW-1:0] lm, fi, sm, rm,
                        input logic ps, pp, ec);
      logic [W-1:0] e;
      int           d;
      rst = r; sr_load = ld; load_mask = lm; flags_in = fi;
      set_mask = sm; reset_mask = rm; push = ps; pop = pp; err_clr = ec;
      model_step(r, ld, lm, fi, sm, rm, ps, pp, ec);
      d = m_stk.size();
      exp_q.push_back({m_flags, CW'(d), (d == SD), (d == 0), m_ovf, m_unf});
      @(negedge clk);
      #2;
      e = exp_q.pop_front();
      check("flags_out", 32'(flags_out), 32'(e[W-1 -: FW]));
      check("depth",     32'(depth),     32'(e[3+CW:4]));
      check("full",      32'(full),      32'(e[3]));
      check("empty",     32'(empty),     32'(e[2]));
      check("ovf_err",   32'(ovf_err),   32'(e[1]));
      check("unf_err",   32'(unf_err),   32'(e[0]));
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_load(input logic [FW-1:0] v, input logic ps, pp);
      drive(1'b0, 1'b1, 4'hF, v, '0, '0, ps, pp, 1'b0);
   endtask

   task automatic do_idle(input logic ps, pp, ec);
      drive(1'b0, 1'b0, '0, '0, '0, '0, ps, pp, ec);
   endtask

   initial begin
      rst = 1'b1; sr_load = 1'b0; load_mask = '0; flags_in = '0;
      set_mask = '0; reset_mask = '0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
      m_flags = '0; m_ovf = 1'b0; m_unf = 1'b0;
      #2;

      // 1: reset with every other input active
      drive(1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0);
      check("rst_flags", 32'(flags_out), 32'h0);
      check("rst_empty", 32'(empty), 32'h1);

      // 2: load low bits, set beats reset on bit2, bit3 holds
      drive(1'b0, 1'b1, 4'b0011, 4'b1111, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
      check("prio_flags", 32'(flags_out), 32'b0111);

      // 3: two saves and two restores
      do_load(4'b0101, 1'b0, 1'b0);
      do_idle(1'b1, 1'b0, 1'b0);
      check("s3_push1", 32'({flags_out, depth}), 32'({4'b0101, 3'd1}));
      do_load(4'b1010, 1'b0, 1'b0);
      do_idle(1'b1, 1'b0, 1'b0);
      check("s3_push2", 32'({flags_out, depth}), 32'({4'b1010, 3'd2}));
      do_idle(1'b0, 1'b1, 1'b0);
      check("s3_pop1", 32'({flags_out, depth}), 32'({4'b1010, 3'd1}));
      do_idle(1'b0, 1'b1, 1'b0);
      check("s3_pop2", 32'({flags_out, depth}), 32'({4'b0101, 3'd0}));

      // 4: overflow on the fifth push, then restore in reverse order
      do_reset();
      for (int i = 0; i < 5; i++) do_load(FW'(i + 1), 1'b1, 1'b0);
      check("s4_full", 32'({depth, full, ovf_err}), 32'({3'd4, 1'b1, 1'b1}));
      for (int i = 0; i < 4; i++) begin
         do_idle(1'b0, 1'b1, 1'b0);
         check("s4_restore", 32'(flags_out), 32'(3 - i));
      end

      // 5: underflow with normal update, then clear; error beats err_clr
      do_reset();
      drive(1'b0, 1'b0, '0, '0, 4'b0001, '0, 1'b0, 1'b1, 1'b0);
      check("s5_unf", 32'({unf_err, depth, flags_out}), 32'({1'b1, 3'd0, 4'b0001}));
      do_idle(1'b0, 1'b0, 1'b1);
      check("s5_clr", 32'(unf_err), 32'h0);
      do_idle(1'b0, 1'b1, 1'b1);
      check("s5_err_wins", 32'(unf_err), 32'h1);
      do_idle(1'b1, 1'b1, 1'b1);
      check("s5_pp_empty", 32'({depth, unf_err}), 32'({3'd1, 1'b1}));

      // 6: exchange
      do_reset();
      do_load(4'b0011, 1'b0, 1'b0);
      do_idle(1'b1, 1'b0, 1'b0);
      do_load(4'b1100, 1'b0, 1'b0);
      do_idle(1'b1, 1'b1, 1'b0);
      check("s6_xchg", 32'({flags_out, depth}), 32'({4'b0011, 3'd1}));
      do_idle(1'b0, 1'b1, 1'b0);
      check("s6_top", 32'({flags_out, depth}), 32'({4'b1100, 3'd0}));

      // exchange while full leaves depth and ovf_err alone
      do_reset();
      for (int i = 0; i < 4; i++) do_load(FW'(8 + i), 1'b1, 1'b0);
      do_idle(1'b1, 1'b1, 1'b0);
      check("xchg_full", 32'({depth, ovf_err, flags_out}), 32'({3'd4, 1'b0, 4'd10}));

      // random phase, including occasional mid-sequence resets
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 39) == 0),
               1'($urandom_range(0, 1)),
               FW'($urandom_range(0, 15)), FW'($urandom_range(0, 15)),
               FW'($urandom_range(0, 15) & $urandom_range(0, 15)),
               FW'($urandom_range(0, 15) & $urandom_range(0, 15)),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 7) == 0));
      end

      check("sb_drained", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
